// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, stall constants, exception codes and bus field offsets for mem_stage
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 229;
  localparam int MEM_TO_WB_WD = 136;  // 32+1+32+1+32+1+5+32
  localparam int STALL_W      = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int   STALL_MEM = 3;
  localparam int   STALL_WB  = 4;

  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  // EX->MEM field offsets, ex_result at the bottom up to badvaddr; [228:224] spare
  localparam int EX_RESULT_LSB  = 0;
  localparam int EX_WADDR_LSB   = 32;
  localparam int EX_RF_WE_BIT   = 37;
  localparam int EX_PC_LSB      = 38;
  localparam int EX_LO_WE_BIT   = 70;
  localparam int EX_LO_LSB      = 71;
  localparam int EX_HI_WE_BIT   = 103;
  localparam int EX_HI_LSB      = 104;
  localparam int EX_SEL_RF_BIT  = 136;
  localparam int EX_RAM_SEL_LSB = 137;
  localparam int EX_LB_BIT      = 141;
  localparam int EX_LBU_BIT     = 142;
  localparam int EX_LH_BIT      = 143;
  localparam int EX_LHU_BIT     = 144;
  localparam int EX_CP0_WE_BIT  = 145;
  localparam int EX_CP0_ADR_LSB = 146;
  localparam int EX_CP0_SEL_LSB = 151;
  localparam int EX_CP0_DAT_LSB = 154;
  localparam int EX_EXC_LSB     = 186;
  localparam int EX_DS_BIT      = 191;
  localparam int EX_BADV_LSB    = 192;
  localparam int EX_RSVD_LSB    = 224;

  // MEM->WB field offsets
  localparam int WB_WDATA_LSB = 0;
  localparam int WB_WADDR_LSB = 32;
  localparam int WB_RF_WE_BIT = 37;
  localparam int WB_PC_LSB    = 38;
  localparam int WB_LO_WE_BIT = 70;
  localparam int WB_LO_LSB    = 71;
  localparam int WB_HI_WE_BIT = 103;
  localparam int WB_HI_LSB    = 104;

  typedef enum logic {
    ST_HELD  = 1'b0,
    ST_FRESH = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_load_ext.sv
// rtl/mem_stage_load_ext.sv - byte/half/word extraction and sign/zero extension of load data
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [3:0]  sel_i,
  input  logic        inst_lb_i,
  input  logic        inst_lbu_i,
  input  logic        inst_lh_i,
  input  logic        inst_lhu_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        byte_ok;
  logic        half_ok;

  always_comb begin
    byte_v  = 8'h00;
    byte_ok = 1'b1;
    case (sel_i)
      4'b0001: byte_v = raw_i[7:0];
      4'b0010: byte_v = raw_i[15:8];
      4'b0100: byte_v = raw_i[23:16];
      4'b1000: byte_v = raw_i[31:24];
      default: byte_ok = 1'b0;
    endcase
  end

  always_comb begin
    half_v  = 16'h0000;
    half_ok = 1'b1;
    case (sel_i)
      4'b0011: half_v = raw_i[15:0];
      4'b1100: half_v = raw_i[31:16];
      default: half_ok = 1'b0;
    endcase
  end

  always_comb begin
    result_o = raw_i;
    if (inst_lb_i || inst_lbu_i) begin
      result_o = !byte_ok ? 32'h0 :
                 {{24{inst_lb_i & byte_v[7]}}, byte_v};
    end else if (inst_lh_i || inst_lhu_i) begin
      result_o = !half_ok ? 32'h0 :
                 {{16{inst_lh_i & half_v[15]}}, half_v};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: bus register, load data hold/extract, exception squash and report
// Optional HI/LO forwarding outputs enabled by MEM_HILO_FWD_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    mem_to_id_we,
  output logic [4:0]              mem_to_id_waddr,
  output logic [31:0]             mem_to_id_wdata,
  output logic                    mem_hi_we,
  output logic                    mem_lo_we,
  output logic [31:0]             mem_hi_wdata,
  output logic [31:0]             mem_lo_wdata,
  output logic                    excp_valid,
  output logic [4:0]              excp_type,
  output logic [31:0]             excp_epc,
  output logic [31:0]             excp_badvaddr,
  output logic                    excp_bd,
  output logic                    cp0_we,
  output logic [4:0]              cp0_waddr,
  output logic [2:0]              cp0_wsel,
  output logic [31:0]             cp0_wdata
);

  logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
  mem_state_e              state_q, state_d;
  logic [31:0]             hold_q, hold_d;

  always_comb begin
    bus_d   = bus_q;
    state_d = ST_HELD;
    if (flush) begin
      bus_d = '0;
    end else if (stall[STALL_MEM] == NO_STOP) begin
      bus_d = ex_to_mem_bus;
      if (ex_to_mem_bus != '0) state_d = ST_FRESH;
    end else if (stall[STALL_WB] == NO_STOP) begin
      bus_d = '0;
    end
  end

  // SRAM data is only valid in the first cycle; keep it for the rest of a stall
  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_FRESH) hold_d = data_sram_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_q   <= '0;
      state_q <= ST_HELD;
      hold_q  <= '0;
    end else begin
      bus_q   <= bus_d;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  logic        fresh;
  logic        exc;
  logic [31:0] raw;
  logic [31:0] ext;
  logic [31:0] pc;
  logic [31:0] rf_wdata;
  logic        rf_we_s, hi_we_s, lo_we_s;

  assign fresh = (state_q == ST_FRESH);
  assign exc   = (bus_q[EX_EXC_LSB +: 5] != EXC_NONE);
  assign raw   = fresh ? data_sram_rdata : hold_q;
  assign pc    = bus_q[EX_PC_LSB +: 32];

  load_ext u_load_ext (
    .raw_i      (raw),
    .sel_i      (bus_q[EX_RAM_SEL_LSB +: 4]),
    .inst_lb_i  (bus_q[EX_LB_BIT]),
    .inst_lbu_i (bus_q[EX_LBU_BIT]),
    .inst_lh_i  (bus_q[EX_LH_BIT]),
    .inst_lhu_i (bus_q[EX_LHU_BIT]),
    .result_o   (ext)
  );

  assign rf_wdata = bus_q[EX_SEL_RF_BIT] ? ext : bus_q[EX_RESULT_LSB +: 32];
  assign rf_we_s  = bus_q[EX_RF_WE_BIT] & ~exc;
  assign hi_we_s  = bus_q[EX_HI_WE_BIT] & ~exc;
  assign lo_we_s  = bus_q[EX_LO_WE_BIT] & ~exc;

  assign mem_to_wb_bus = {bus_q[EX_HI_LSB +: 32], hi_we_s,
                          bus_q[EX_LO_LSB +: 32], lo_we_s,
                          pc, rf_we_s, bus_q[EX_WADDR_LSB +: 5], rf_wdata};

  assign mem_to_id_we    = rf_we_s;
  assign mem_to_id_waddr = bus_q[EX_WADDR_LSB +: 5];
  assign mem_to_id_wdata = rf_wdata;

`ifdef MEM_HILO_FWD_EN
  assign mem_hi_we    = hi_we_s;
  assign mem_lo_we    = lo_we_s;
  assign mem_hi_wdata = bus_q[EX_HI_LSB +: 32];
  assign mem_lo_wdata = bus_q[EX_LO_LSB +: 32];
`else
  assign mem_hi_we    = 1'b0;
  assign mem_lo_we    = 1'b0;
  assign mem_hi_wdata = 32'h0;
  assign mem_lo_wdata = 32'h0;
`endif

  // Reported and committed only in the first cycle so stalls cannot repeat them
  assign excp_valid    = fresh & exc;
  assign excp_type     = bus_q[EX_EXC_LSB +: 5];
  assign excp_bd       = bus_q[EX_DS_BIT];
  assign excp_epc      = bus_q[EX_DS_BIT] ? pc - 32'd4 : pc;
  assign excp_badvaddr = bus_q[EX_BADV_LSB +: 32];

  assign cp0_we    = fresh & bus_q[EX_CP0_WE_BIT] & ~exc;
  assign cp0_waddr = bus_q[EX_CP0_ADR_LSB +: 5];
  assign cp0_wsel  = bus_q[EX_CP0_SEL_LSB +: 3];
  assign cp0_wdata = bus_q[EX_CP0_DAT_LSB +: 32];

  logic unused_bits;
  assign unused_bits = ^{stall[2:0], stall[5], bus_q[EX_TO_MEM_WD-1:EX_RSVD_LSB]};

endmodule
